instruction_fetch_stage: RTL

Parametrised fetch stage for the MIPS pipeline: owns the PC, the instruction memory and the IF/ID pipeline register. It adds three things: a valid/ready loader port through which the debug unit fills memory, branch/jump redirect with flush, and halt detection. A control FSM sequences IDLE, LOAD, RUN and HALT. It feeds the decode stage and is driven by the debug unit and the hazard/branch logic.

---
 rtl/if_stage_pkg.sv | 31 +++
 rtl/instr_ram.sv | 27 ++
 rtl/instruction_fetch_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding,
// the NOP and default halt opcodes, and the IF/ID register layout.
package if_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } if_state_e;

    localparam int          IFID_W             = 32;
    localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HALT_INSTR = 32'hFFFF_FFFF;

    // IF/ID register layout, sized for the 32-bit pipeline.
    typedef struct packed {
        logic [IFID_W-1:0] instr;
        logic [IFID_W-1:0] pc;
        logic [IFID_W-1:0] pc_plus4;
        logic              valid;
    } ifid_t;

    localparam ifid_t IFID_NOP = '{
        instr:    NOP_INSTR,
        pc:       32'h0000_0000,
        pc_plus4: 32'h0000_0000,
        valid:    1'b0
    };

endpackage

// File: rtl/instr_ram.sv
// Instruction memory: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a reload survives a reset.
module instr_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Loader write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC, instruction memory, IF/ID register and IDLE/LOAD/RUN/HALT control.
// Defining IF_STEP_EN adds i_step_mode/i_step to gate fetch advances one step at a time.
module instruction_fetch_stage
    import if_stage_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 64,
    parameter int                ADDR_W     = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] RESET_PC   = {DATA_W{1'b0}},
    parameter logic [DATA_W-1:0] HALT_INSTR = DEFAULT_HALT_INSTR
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_load_start,
    input  logic              i_load_valid,
    input  logic              i_load_last,
    input  logic [DATA_W-1:0] i_load_data,
    output logic              o_load_ready,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_target,
`ifdef IF_STEP_EN
    input  logic              i_step_mode,
    input  logic              i_step,
`endif
    output logic [DATA_W-1:0] o_instr,
    output logic [DATA_W-1:0] o_pc,
    output logic [DATA_W-1:0] o_pc_plus4,
    output logic              o_valid,
    output logic [1:0]        o_state,
    output logic              o_halted,
    output logic [ADDR_W:0]   o_load_count
);

    localparam logic [DATA_W:0]   PC_LIMIT  = (DATA_W+1)'(DEPTH * 4);
    localparam logic [ADDR_W:0]   CNT_LAST  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [DATA_W-1:0] PC_STEP   = DATA_W'(4);
    localparam logic [DATA_W-1:0] WORD_MASK = {{(DATA_W-2){1'b1}}, 2'b00};

    if_state_e         state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    ifid_t             ifid_q, ifid_d;

    logic              we_s;
    logic [DATA_W-1:0] rdata_s;
    logic [DATA_W-1:0] pc_plus4_s;
    logic              pc_out_of_range_s;
    logic              hold_s;

    instr_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_instr_ram (
        .i_clk   (i_clk),
        .i_we    (we_s),
        .i_waddr (cnt_q[ADDR_W-1:0]),
        .i_wdata (i_load_data),
        .i_raddr (pc_q[ADDR_W+1:2]),
        .o_rdata (rdata_s)
    );

    assign pc_plus4_s        = pc_q + PC_STEP;
    assign pc_out_of_range_s = ({1'b0, pc_q} >= PC_LIMIT);

`ifdef IF_STEP_EN
    assign hold_s = i_stall | (i_step_mode & ~i_step);
`else
    assign hold_s = i_stall;
`endif

    // Next-state, PC, loader count and IF/ID selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ifid_d  = ifid_q;
        we_s    = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                ifid_d = IFID_NOP;
                if (i_start) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end else if (i_load_start) begin
                    state_d = ST_LOAD;
                    cnt_d   = {(ADDR_W+1){1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                ifid_d = IFID_NOP;
                if (i_load_valid) begin
                    we_s  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    // A full memory ends the load even without a last marker.
                    if (i_load_last || (cnt_q == CNT_LAST)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (i_flush) begin
                    pc_d   = i_target & WORD_MASK;
                    ifid_d = IFID_NOP;
                end else if (hold_s) begin
                    pc_d   = pc_q;
                    ifid_d = ifid_q;
                end else if (pc_out_of_range_s) begin
                    ifid_d  = IFID_NOP;
                    state_d = ST_HALT;
                end else begin
                    ifid_d.instr    = rdata_s;
                    ifid_d.pc       = pc_q;
                    ifid_d.pc_plus4 = pc_plus4_s;
                    ifid_d.valid    = 1'b1;
                    // The halt opcode is issued but the PC stays on it.
                    if (rdata_s == HALT_INSTR) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_plus4_s;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ifid_d  = IFID_NOP;
            end
        endcase
    end

    // State, PC, loader count and IF/ID registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= {(ADDR_W+1){1'b0}};
            ifid_q  <= IFID_NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ifid_q  <= ifid_d;
        end
    end

    assign o_instr      = ifid_q.instr;
    assign o_pc         = ifid_q.pc;
    assign o_pc_plus4   = ifid_q.pc_plus4;
    assign o_valid      = ifid_q.valid;
    assign o_state      = state_q;
    assign o_halted     = (state_q == ST_HALT);
    assign o_load_ready = (state_q == ST_LOAD);
    assign o_load_count = cnt_q;

endmodule
